// File: rtl/riscv_pkg.sv
// Shared pipeline definitions used by fetch, decode and the hazard unit.
package riscv_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 6;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned COUNT_W = 16;

    // addi x0,x0,0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] cnt);
        return (cnt == {COUNT_W{1'b1}}) ? cnt : cnt + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction store: asynchronous read, synchronous write, no reset on contents.
module instr_rom
    import riscv_pkg::*;
(
    input  logic               clock,
    input  logic               i_we,
    input  logic [PC_W-1:0]    i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [PC_W-1:0]    i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read sees the pre-write word when addresses collide in the same cycle.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one-entry skid buffer and PC redirect on long stalls.
module fetch_stage
    import riscv_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               stall,
    input  logic               flush,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               id_valid,
    output logic               redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [COUNT_W-1:0] fetch_count
);

    fetch_state_e       r_state;
    logic [INSTR_W-1:0] r_id_instr;
    logic [PC_W-1:0]    r_id_pc;
    logic               r_id_valid;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [PC_W-1:0]    r_skid_pc;
    logic [COUNT_W-1:0] r_fetch_count;
    logic [INSTR_W-1:0] w_rom_data;
    logic               w_redirect;

    instr_rom u_rom (
        .clock   (clock),
        .i_we    (prog_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (pc_in),
        .o_rdata (w_rom_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= BOOT;
            r_id_instr    <= NOP;
            r_id_pc       <= '0;
            r_id_valid    <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_fetch_count <= '0;
        end else begin
            unique case (r_state)
                BOOT: begin
                    // PC comes out of reset at 63, so the first edge is a bubble.
                    r_id_instr <= NOP;
                    r_id_valid <= 1'b0;
                    r_state    <= RUN;
                end
                RUN: begin
                    if (flush) begin
                        r_id_instr <= NOP;
                        r_id_valid <= 1'b0;
                    end else if (stall) begin
                        r_skid_instr <= w_rom_data;
                        r_skid_pc    <= pc_in;
                        r_state      <= HOLD;
                    end else begin
                        r_id_instr    <= w_rom_data;
                        r_id_pc       <= pc_in;
                        r_id_valid    <= 1'b1;
                        r_fetch_count <= sat_inc(r_fetch_count);
                    end
                end
                HOLD: begin
                    if (flush) begin
                        r_skid_instr <= '0;
                        r_skid_pc    <= '0;
                        r_id_instr   <= NOP;
                        r_id_valid   <= 1'b0;
                        r_state      <= RUN;
                    end else if (!stall) begin
                        // Drain the skid; pc_in on this edge is deliberately dropped.
                        r_id_instr    <= r_skid_instr;
                        r_id_pc       <= r_skid_pc;
                        r_id_valid    <= 1'b1;
                        r_fetch_count <= sat_inc(r_fetch_count);
                        r_state       <= RUN;
                    end
                end
                default: begin
                    r_state <= BOOT;
                end
            endcase
        end
    end

    assign w_redirect = (r_state == HOLD) && stall && !flush;

    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_valid    = r_id_valid;
    assign redirect    = w_redirect;
    // Only meaningful while redirect is high; parked at zero otherwise.
    assign redirect_pc = w_redirect ? pc_inc(r_skid_pc) : '0;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench: each directed cycle pushes its expected snapshot, a negedge monitor compares.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic [5:0]  pc_in;
    logic        stall;
    logic        flush;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] id_instr;
    logic [5:0]  id_pc;
    logic        id_valid;
    logic        redirect;
    logic [5:0]  redirect_pc;
    logic [15:0] fetch_count;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    typedef struct {
        int          cyc;
        logic        valid;
        logic [5:0]  pc;
        logic [31:0] instr;
        logic        redir;
        logic [5:0]  rpc;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    fetch_stage dut (
        .clock       (clock),
        .reset       (reset),
        .pc_in       (pc_in),
        .stall       (stall),
        .flush       (flush),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_valid    (id_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input int cyc, input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle %0d %s: got %h expected %h", cyc, name, got, want);
        end
    endtask

    // Monitor: the DUT presents a fresh snapshot every cycle; compare at negedge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.cyc, "id_valid", 32'(id_valid), 32'(e.valid));
            chk(e.cyc, "id_pc", 32'(id_pc), 32'(e.pc));
            chk(e.cyc, "id_instr", id_instr, e.instr);
            chk(e.cyc, "redirect", 32'(redirect), 32'(e.redir));
            chk(e.cyc, "redirect_pc", 32'(redirect_pc), 32'(e.rpc));
            chk(e.cyc, "fetch_count", 32'(fetch_count), 32'(e.cnt));
        end
    end

    // Called just after a posedge: drive inputs for this cycle, push the expected view, run the edge.
    task automatic cyc(input logic rst, input logic [5:0] pc, input logic st, input logic fl,
                       input logic we, input logic [5:0] wa, input logic [31:0] wd,
                       input logic ev, input logic [5:0] epc, input logic [31:0] ei,
                       input logic er, input logic [5:0] erp, input logic [15:0] ec);
        exp_t e;
        reset     = rst;
        pc_in     = pc;
        stall     = st;
        flush     = fl;
        prog_we   = we;
        prog_addr = wa;
        prog_data = wd;
        e.cyc   = cyc_no;
        e.valid = ev;
        e.pc    = epc;
        e.instr = ei;
        e.redir = er;
        e.rpc   = erp;
        e.cnt   = ec;
        exp_q.push_back(e);
        cyc_no++;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] w(input int i);
        return 32'h0000_00A0 + 32'(i);
    endfunction

    initial begin
        reset     = 1'b1;
        pc_in     = 6'd63;
        stall     = 1'b0;
        flush     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 64; i++) begin
            prog_we   = 1'b1;
            prog_addr = 6'(i);
            prog_data = w(i);
            @(posedge clock);
            #1;
        end
        prog_we = 1'b0;

        //  rst pc  st fl  we wa  wd       | valid pc  instr  redir rpc cnt
        cyc(0, 63, 0, 0, 0, 0, 0,  0, 0,  NOP_W, 0, 0, 16'd0);   // BOOT bubble edge
        cyc(0, 0,  0, 0, 0, 0, 0,  0, 0,  NOP_W, 0, 0, 16'd0);
        cyc(0, 1,  0, 0, 0, 0, 0,  1, 0,  w(0),  0, 0, 16'd1);
        cyc(0, 2,  1, 0, 0, 0, 0,  1, 1,  w(1),  0, 0, 16'd2);   // 3-cycle stall at pc 2
        cyc(0, 3,  1, 0, 0, 0, 0,  1, 1,  w(1),  1, 3, 16'd2);
        cyc(0, 3,  1, 0, 0, 0, 0,  1, 1,  w(1),  1, 3, 16'd2);
        cyc(0, 3,  0, 0, 0, 0, 0,  1, 1,  w(1),  0, 0, 16'd2);   // drain edge
        cyc(0, 3,  0, 0, 0, 0, 0,  1, 2,  w(2),  0, 0, 16'd3);
        cyc(0, 4,  0, 0, 0, 0, 0,  1, 3,  w(3),  0, 0, 16'd4);
        cyc(0, 5,  1, 0, 0, 0, 0,  1, 4,  w(4),  0, 0, 16'd5);   // single-cycle stall
        cyc(0, 6,  0, 0, 0, 0, 0,  1, 4,  w(4),  0, 0, 16'd5);
        cyc(0, 6,  0, 0, 0, 0, 0,  1, 5,  w(5),  0, 0, 16'd6);
        cyc(0, 7,  1, 0, 0, 0, 0,  1, 6,  w(6),  0, 0, 16'd7);   // enter HOLD
        cyc(0, 8,  1, 1, 0, 0, 0,  1, 6,  w(6),  0, 0, 16'd7);   // flush + stall in HOLD
        cyc(0, 10, 0, 0, 0, 0, 0,  0, 6,  NOP_W, 0, 0, 16'd7);   // branch target
        cyc(0, 11, 1, 0, 0, 0, 0,  1, 10, w(10), 0, 0, 16'd8);
        cyc(0, 12, 1, 0, 0, 0, 0,  1, 10, w(10), 1, 12, 16'd8);  // HOLD, redirect high
        cyc(1, 12, 1, 0, 0, 0, 0,  0, 0,  NOP_W, 0, 0, 16'd0);   // async reset in HOLD
        cyc(0, 63, 0, 0, 0, 0, 0,  0, 0,  NOP_W, 0, 0, 16'd0);   // BOOT bubble again
        cyc(0, 0,  0, 0, 0, 0, 0,  0, 0,  NOP_W, 0, 0, 16'd0);
        cyc(0, 1,  0, 0, 0, 0, 0,  1, 0,  w(0),  0, 0, 16'd1);

        force dut.r_fetch_count = 16'hFFFE;
        #1;
        release dut.r_fetch_count;

        cyc(0, 62, 0, 0, 0, 0, 0,  1, 1,  w(1),  0, 0, 16'hFFFE);
        cyc(0, 63, 0, 0, 0, 0, 0,  1, 62, w(62), 0, 0, 16'hFFFF);
        cyc(0, 0,  0, 0, 0, 0, 0,  1, 63, w(63), 0, 0, 16'hFFFF); // PC wrap
        cyc(0, 1,  0, 0, 1, 1, 32'h1234_5678,
                                   1, 0,  w(0),  0, 0, 16'hFFFF); // write-during-read
        cyc(0, 1,  0, 0, 0, 0, 0,  1, 1,  w(1),  0, 0, 16'hFFFF);
        cyc(0, 2,  0, 0, 0, 0, 0,  1, 1,  32'h1234_5678, 0, 0, 16'hFFFF);
        cyc(0, 63, 1, 0, 0, 0, 0,  1, 2,  w(2),  0, 0, 16'hFFFF); // stall at pc 63
        cyc(0, 0,  1, 0, 0, 0, 0,  1, 2,  w(2),  1, 0, 16'hFFFF);
        cyc(0, 0,  0, 0, 0, 0, 0,  1, 2,  w(2),  0, 0, 16'hFFFF);
        cyc(0, 0,  0, 0, 0, 0, 0,  1, 63, w(63), 0, 0, 16'hFFFF);
        cyc(0, 1,  0, 0, 0, 0, 0,  1, 0,  w(0),  0, 0, 16'hFFFF);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register, directly downstream of the program counter. Each cycle it reads the 64-entry instruction store at the current PC, registers the instruction and its PC for decode, and handles stall and flush. A one-entry skid buffer keeps the instruction that arrives on the first stall cycle. While the stall persists, a redirect pins the PC.

## Interface
- NOP, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- DEPTH, 64, instruction words (PC width 6)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- pc_in  in  6  current PC from program counter
- stall  in  1  hazard unit: hold IF/ID
- flush  in  1  taken branch/jump from execute: kill fetched instruction
- prog_we  in  1  instruction-store write enable (bench/loader)
- prog_addr  in  6  write address
- prog_data  in  32  write data
- id_instr  out  32  registered instruction to decode
- id_pc  out  6  registered PC of id_instr
- id_valid  out  1  id_instr is a real instruction
- redirect  out  1  drives PC succ input: reload PC
- redirect_pc  out  6  drives PC new_addr (zero-extended by PC)
- fetch_count  out  16  instructions delivered to decode, saturating

## Operation
- Instruction store: DEPTH x 32, asynchronous read at pc_in, synchronous write on prog_we. Same-cycle read/write to one address returns the old word. Contents are not cleared by reset.
- States:
  - BOOT: one bubble edge, because PC sits at 63 out of reset.
  - RUN: normal fetch.
  - HOLD: IF/ID frozen, skid holds one entry.
- Priority at every edge: flush > stall > normal.
- BOOT, any inputs: id_valid=0, id_instr=NOP. Go to RUN.
- RUN:
  - flush: load NOP, id_valid=0, stay in RUN.
  - stall: IF/ID unchanged. Skid <= {rom[pc_in], pc_in}. Go to HOLD.
  - else: id_instr<=rom[pc_in], id_pc<=pc_in, id_valid=1, fetch_count++.
- HOLD:
  - flush: clear skid, load NOP, id_valid=0, go to RUN.
  - stall: all registers unchanged, stay in HOLD.
  - else: IF/ID <= skid, id_valid=1, fetch_count++, go to RUN. pc_in at this edge is not captured.
- redirect = (state==HOLD) && stall && !flush, combinational.
- redirect_pc = skid_pc+1 mod 64. This pins the PC so that skid_pc+1 is the next address fetched after the drain.
- Flush does not re-fetch: the PC receives the branch target from execute and the target is fetched normally in RUN on the next edge.
- fetch_count saturates at 16'hFFFF and does not wrap.

## Timing
- Reset values:
  - outputs: id_instr=NOP, id_pc=0, id_valid=0, redirect=0, redirect_pc=0, fetch_count=0.
  - internal: state=BOOT, skid cleared.
- Reset mid-operation: immediate return to these values, including from HOLD. The skid is discarded.
- Latency: pc_in sampled at edge N appears on id_instr/id_pc after edge N.
- First valid instruction is PC 0, visible after the second edge following reset release.
- Stall of k cycles starting at edge N (pc_in=p at N):
  - id outputs are frozen from edge N through N+k-1.
  - redirect is high during cycles N+1..N+k-1.
  - p appears after edge N+k.
  - p+1 is captured at edge N+k+1.
- Single-cycle stall: no redirect. PC naturally presents p+1 at the drain edge and again at the following edge, because the PC advances only after the drain.
- PC wrap: 63 -> 0. A skid_pc of 63 gives redirect_pc=0.

## Structure
- Shared package riscv_pkg holds the items used by decode and the hazard unit:
  - NOP constant
  - PC_W=6
  - INSTR_W=32
  - fetch state enum {BOOT, RUN, HOLD}
- Sub-module instr_rom: DEPTH x 32 array, async read port, sync write port. fetch_stage instantiates it once.

## Test plan
- Reset then load words 0..3 = 32'hA0..A3 with a free-running PC -> first edge gives id_valid=0; then id_pc 0,1,2,3 with id_instr A0..A3 and fetch_count=4.
- Stall for 3 cycles when pc_in=2 -> id holds entry 1. redirect=1 for 2 cycles with redirect_pc=3. Then id shows 2 (A2), then 3 (A3); no instruction lost or duplicated.
- Single-cycle stall at pc_in=5 -> redirect never asserted; id sequence 4,4,5,6.
- Flush and stall together in HOLD -> id_instr=NOP, id_valid=0, redirect=0, skid cleared; next edge captures the branch target.
- Assert reset while in HOLD -> all outputs return to reset values immediately; the next sequence starts with the BOOT bubble.
- Preload fetch_count to FFFE, e.g. via a force, and run 4 fetches -> count reads FFFF and stays there; PC wrap 63->0 fetches word 0 with id_pc=0.
